// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Default geometry shared by the FIFO pair and its RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;
  localparam int c_ADDR_SIZE = 2;
  localparam int c_WORD_SIZE = 8;
endpackage : fifo_pkg

`default_nettype wire

// File: rtl/ram.sv
// ============================================================================
// Module      : ram
// Description : Simple dual-port RAM, synchronous write and read, old data on
//               read-during-write to the same address. No reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE = c_ADDR_SIZE,
  parameter int WORD_SIZE = c_WORD_SIZE
) (
  input  logic                 clk,
  input  logic [ADDR_SIZE-1:0] w_addr,
  input  logic [WORD_SIZE-1:0] w_data,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] r_addr,
  output logic [WORD_SIZE-1:0] r_data
);

  localparam int c_DEPTH = 1 << ADDR_SIZE;

  logic [WORD_SIZE-1:0] r_mem [c_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[w_addr] <= w_data;
    end
    r_data <= r_mem[r_addr];
  end

endmodule : ram

`default_nettype wire

// File: rtl/fifo_pair_top.sv
// ============================================================================
// Module      : fifo_pair_top
// Description : One write/read stream driving a standard FIFO and a
//               first-word-fall-through FIFO in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_pair_top
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE = c_ADDR_SIZE,
  parameter int WORD_SIZE = c_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_we,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_re,
  output logic                 o_is_not_full_standart,
  output logic                 o_is_not_full_fwft,
  output logic                 o_is_not_empty_standart,
  output logic                 o_is_not_empty_fwft,
  output logic [WORD_SIZE-1:0] o_data_standart,
  output logic [WORD_SIZE-1:0] o_data_fwft
);

  localparam int c_STD  = 0;
  localparam int c_FWFT = 1;

  logic [1:0]                w_not_full;
  logic [1:0]                w_not_empty;
  logic [1:0][WORD_SIZE-1:0] w_dout;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [ADDR_SIZE:0]   r_wr_ptr;
    logic [ADDR_SIZE:0]   r_rd_ptr;
    logic [ADDR_SIZE:0]   w_rd_next;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_we_acc;
    logic                 w_re_acc;
    logic [ADDR_SIZE-1:0] w_r_addr;
    logic [WORD_SIZE-1:0] w_r_data;

    // MSB is the wrap bit: equal pointers mean empty, differing wrap bits full
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[ADDR_SIZE] != r_rd_ptr[ADDR_SIZE]) &&
                       (r_wr_ptr[ADDR_SIZE-1:0] == r_rd_ptr[ADDR_SIZE-1:0]);
    assign w_we_acc  = i_we && !w_full;
    assign w_re_acc  = i_re && !w_empty;
    assign w_rd_next = r_rd_ptr + {{ADDR_SIZE{1'b0}}, w_re_acc};

    always_ff @(posedge clk) begin
      if (reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_we_acc) begin
          r_wr_ptr <= r_wr_ptr + {{ADDR_SIZE{1'b0}}, 1'b1};
        end
        r_rd_ptr <= w_rd_next;
      end
    end

    ram #(
      .ADDR_SIZE (ADDR_SIZE),
      .WORD_SIZE (WORD_SIZE)
    ) u_ram (
      .clk    (clk),
      .w_addr (r_wr_ptr[ADDR_SIZE-1:0]),
      .w_data (i_data),
      .we     (w_we_acc),
      .r_addr (w_r_addr),
      .r_data (w_r_data)
    );

    assign w_not_full[g]  = !w_full;
    assign w_not_empty[g] = !w_empty;

    if (g == c_STD) begin : g_std
      logic                 r_pop_d;
      logic [WORD_SIZE-1:0] r_hold_q;
      logic [WORD_SIZE-1:0] w_out;

      assign w_r_addr = r_rd_ptr[ADDR_SIZE-1:0];
      assign w_out    = r_pop_d ? w_r_data : r_hold_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_pop_d  <= 1'b0;
          r_hold_q <= '0;
        end else begin
          r_pop_d  <= w_re_acc;
          r_hold_q <= w_out;
        end
      end

      assign w_dout[g] = w_out;
    end else begin : g_fwft
      logic                 r_byp;
      logic [WORD_SIZE-1:0] r_byp_data;
      logic                 w_byp;

      // Look one word ahead on a pop so the next head is ready after the edge
      assign w_r_addr = w_rd_next[ADDR_SIZE-1:0];
      assign w_byp    = w_we_acc && (r_wr_ptr[ADDR_SIZE-1:0] == w_r_addr);

      always_ff @(posedge clk) begin
        if (reset) begin
          r_byp      <= 1'b0;
          r_byp_data <= '0;
        end else begin
          r_byp <= w_byp;
          if (w_byp) begin
            r_byp_data <= i_data;
          end
        end
      end

      assign w_dout[g] = w_empty ? '0 : (r_byp ? r_byp_data : w_r_data);
    end
  end

  assign o_is_not_full_standart  = w_not_full[c_STD];
  assign o_is_not_full_fwft      = w_not_full[c_FWFT];
  assign o_is_not_empty_standart = w_not_empty[c_STD];
  assign o_is_not_empty_fwft     = w_not_empty[c_FWFT];
  assign o_data_standart         = w_dout[c_STD];
  assign o_data_fwft             = w_dout[c_FWFT];

endmodule : fifo_pair_top

`default_nettype wire

// File: tb/tb_fifo_pair_top.sv
// ============================================================================
// Module      : tb_fifo_pair_top
// Description : Scoreboard bench for fifo_pair_top against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_pair_top;

  localparam int c_DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_we = 1'b0;
  logic       i_re = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       o_is_not_full_standart;
  logic       o_is_not_full_fwft;
  logic       o_is_not_empty_standart;
  logic       o_is_not_empty_fwft;
  logic [7:0] o_data_standart;
  logic [7:0] o_data_fwft;

  fifo_pair_top #(
    .ADDR_SIZE (2),
    .WORD_SIZE (8)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .i_we                    (i_we),
    .i_data                  (i_data),
    .i_re                    (i_re),
    .o_is_not_full_standart  (o_is_not_full_standart),
    .o_is_not_full_fwft      (o_is_not_full_fwft),
    .o_is_not_empty_standart (o_is_not_empty_standart),
    .o_is_not_empty_fwft     (o_is_not_empty_fwft),
    .o_data_standart         (o_data_standart),
    .o_data_fwft             (o_data_fwft)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       nf;
    logic       ne;
    logic [7:0] ds;
    logic [7:0] df;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  logic [7:0] m_hold = 8'h00;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle and record what the outputs must be after its edge
  task automatic step(input logic rst, input logic we, input logic re, input logic [7:0] d);
    exp_t e;
    bit   full, empty;
    @(negedge clk);
    reset  = rst;
    i_we   = we;
    i_re   = re;
    i_data = d;
    full   = (mq.size() == c_DEPTH);
    empty  = (mq.size() == 0);
    if (rst) begin
      mq.delete();
      m_hold = 8'h00;
    end else begin
      if (re && !empty) m_hold = mq.pop_front();
      if (we && !full) mq.push_back(d);
    end
    e.nf = (mq.size() < c_DEPTH);
    e.ne = (mq.size() > 0);
    e.ds = m_hold;
    e.df = (mq.size() > 0) ? mq[0] : 8'h00;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("not_full_std",  {7'd0, o_is_not_full_standart},  {7'd0, e.nf});
        check("not_full_fwft", {7'd0, o_is_not_full_fwft},      {7'd0, e.nf});
        check("not_empty_std", {7'd0, o_is_not_empty_standart}, {7'd0, e.ne});
        check("not_empty_fwft",{7'd0, o_is_not_empty_fwft},     {7'd0, e.ne});
        check("data_std",      o_data_standart,                 e.ds);
        check("data_fwft",     o_data_fwft,                     e.df);
      end
    end
  end

  initial begin : stim
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h10);
    step(1'b0, 1'b1, 1'b0, 8'h11);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 8'(8'h20 + i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h55);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
    step(1'b0, 1'b1, 1'b1, 8'h99);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 50), 8'($urandom));
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fifo_pair_top

`default_nettype wire

// File: doc/fifo_pair_top.md
# fifo_pair_top

Dual-mode synchronous FIFO wrapper. A single write/read stream drives two identical-depth FIFO channels in lockstep: a standard channel, where read data appears after the pop, and a first-word-fall-through (FWFT) channel, where the head word is presented before the pop. Both channels share one clock, reset and input port, and each keeps its own storage in a `ram` sub-module. The block is used to compare both read disciplines side by side.

## Interface
- `ADDR_SIZE`, default 2: address width; depth = 2^ADDR_SIZE (4 words).
- `WORD_SIZE`, default 8: data word width.

Clock and reset: clk; reset reset, synchronous, active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_we`  in  1  write request.
- `i_data`  in  WORD_SIZE  write data.
- `i_re`  in  1  read/pop request.
- `o_is_not_full_standart`  out  1  standard channel can accept a write.
- `o_is_not_full_fwft`  out  1  FWFT channel can accept a write.
- `o_is_not_empty_standart`  out  1  standard channel holds at least one word.
- `o_is_not_empty_fwft`  out  1  FWFT channel holds at least one word; `o_data_fwft` is valid.
- `o_data_standart`  out  WORD_SIZE  last popped word (standard channel).
- `o_data_fwft`  out  WORD_SIZE  current head word (FWFT channel).

## Operation
- Per channel: `wr_ptr` and `rd_ptr`, each ADDR_SIZE+1 bits; the low ADDR_SIZE bits address the RAM and the MSB is the wrap bit.
- Empty: pointers equal. Full: MSBs differ and low bits equal. Pointers wrap modulo 2^(ADDR_SIZE+1).
- Write accepted: `i_we && !full`. The word is stored at `wr_ptr` and `wr_ptr` increments. A write while full is dropped, even if a read happens in the same cycle.
- Read accepted: `i_re && !empty`. `rd_ptr` increments. A read while empty is ignored, even if a write happens in the same cycle.
- Write and read both accepted in the same cycle: occupancy is unchanged.
- Both channels see identical accepts, so their flags are always equal.
- `ram`: simple dual-port memory with no reset.
  - Write is synchronous on `we`.
  - Read is synchronous: `r_data <= mem[r_addr]` on every edge.
  - Read-during-write to the same address returns the old data.
- Standard channel:
  - `r_addr = rd_ptr`.
  - Registered flag `pop_d` = "read accepted last edge".
  - `o_data_standart = pop_d ? r_data : hold_q`.
  - `hold_q <= o_data_standart` on every edge.
- FWFT channel:
  - `r_addr = rd_ptr + read_accepted` (the next head).
  - Bypass: if the accepted write address equals `r_addr` in the same cycle, register `i_data` and select it instead of `r_data` on the next cycle.
  - `o_data_fwft` is forced to 0 while empty.

## Timing
- Reset values: both not_full = 1, both not_empty = 0, `o_data_standart` = 0, `o_data_fwft` = 0. Pointers, `pop_d`, `hold_q` and the bypass flag are all cleared.
- Reset asserted mid-operation empties both channels at the next edge. Stored words are discarded (RAM contents are not cleared).
- Flags are combinational from registered pointers and update right after the accepting edge.
- Standard: a pop accepted at edge M makes the popped word visible on `o_data_standart` right after M. The value then holds until the next accepted pop.
- FWFT: a write accepted at edge N into an empty FWFT channel sets `o_is_not_empty_fwft` = 1 with `o_data_fwft` = that word right after N.
- FWFT: a pop at edge M presents the next head right after M, or 0 with not_empty = 0 if the channel is now empty.

## Structure
- Shared package `fifo_pkg`: default ADDR_SIZE/WORD_SIZE constants only; no typedefs required.
- One natural sub-module: `ram`, with parameters ADDR_SIZE/WORD_SIZE and ports clk, w_addr, w_data, we, r_addr, r_data. It is instantiated twice, once per channel.
- Pointer and flag logic is identical in both channels; a generate loop or duplicated logic in the top are both acceptable.

## Test plan
- Reset, then idle: not_full = 1, not_empty = 0, both data outputs 0x00.
- Write 0x01..0x05 on 5 consecutive edges:
  - After the 1st edge: not_empty = 1 and `o_data_fwft` = 0x01.
  - After the 4th edge: not_full = 0.
  - 0x05 is dropped.
- From full, hold `i_re` for 5 edges:
  - `o_data_standart` shows 01, 02, 03, 04, then holds 04.
  - `o_data_fwft` shows 02, 03, 04, then 0x00 with not_empty = 0.
  - The 5th read is ignored.
- Simultaneous `i_we` and `i_re` with 2 words stored: occupancy stays 2. Continue for 8 cycles to cross pointer wrap-around; the data order must be preserved.
- `i_we` and `i_re` together while empty: the write is accepted, the read is ignored, and `o_data_fwft` shows the new word.
- `i_we` and `i_re` together while full: the read is accepted, the write is dropped, and not_full = 1 afterwards.
- Assert `reset` with 3 words stored: after the next edge both channels report empty, not_full = 1, and both data outputs are 0x00.
